// File: rtl/campfire_bank.sv
// Bank of NUM_FIRES checkpoint campfires: proximity-driven ignition FSM per channel,
// looping flame animation once lit, and tracking of the most recently lit fire as respawn point.
module campfire_bank #(
   parameter int          NUM_FIRES    = 4,
   parameter logic [9:0]  HIT_W        = 10'd16,
   parameter logic [9:0]  HIT_H        = 10'd16,
   parameter int          IGNITE_TICKS = 8,
   parameter int          NUM_FRAMES   = 4
) (
   input  logic                      sim_clk,
   input  logic                      reset,
   input  logic                      tick,
   input  logic [32*NUM_FIRES-1:0]   initCampfireState,
   input  logic [31:0]               playerState,
   output logic [32*NUM_FIRES-1:0]   campfireState,
   output logic [31:0]               respawnState,
   output logic [3:0]                activeIdx,
   output logic                      litPulse
);

   typedef enum logic [1:0] {
      UNLIT    = 2'b00,
      IGNITING = 2'b01,
      LIT      = 2'b10,
      BAD      = 2'b11
   } st_t;

   logic [9:0] x_q     [NUM_FIRES];
   logic [9:0] y_q     [NUM_FIRES];
   st_t        st_q    [NUM_FIRES];
   st_t        st_d    [NUM_FIRES];
   logic [7:0] cnt_q   [NUM_FIRES];
   logic [7:0] cnt_d   [NUM_FIRES];
   logic [2:0] frame_q [NUM_FIRES];
   logic [2:0] frame_d [NUM_FIRES];
   logic       near    [NUM_FIRES];
   logic       enter_lit [NUM_FIRES];

   logic [31:0] respawn_q, respawn_d;
   logic [3:0]  active_q, active_d;
   logic        lit_pulse_q, lit_pulse_d;
   logic        unused_bits;

   // Distances are taken at 11 bits so that e.g. 5-1020 does not wrap into a small value.
   always_comb begin
      logic [10:0] dx, dy, adx, ady;
      for (int i = 0; i < NUM_FIRES; i++) begin
         dx  = {1'b0, playerState[31:22]} - {1'b0, x_q[i]};
         dy  = {1'b0, playerState[21:12]} - {1'b0, y_q[i]};
         adx = dx[10] ? (~dx + 11'd1) : dx;
         ady = dy[10] ? (~dy + 11'd1) : dy;
         near[i] = (adx[9:0] < HIT_W) && (ady[9:0] < HIT_H);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_FIRES; i++) begin
         st_d[i]      = st_q[i];
         cnt_d[i]     = cnt_q[i];
         frame_d[i]   = frame_q[i];
         enter_lit[i] = 1'b0;
         case (st_q[i])
            UNLIT: begin
               frame_d[i] = 3'd0;
               if (near[i]) begin
                  st_d[i]  = IGNITING;
                  cnt_d[i] = 8'd0;
               end
            end
            IGNITING: begin
               frame_d[i] = 3'd0;
               if (!near[i]) begin
                  st_d[i]  = UNLIT;
                  cnt_d[i] = 8'd0;
               end else if (tick) begin
                  if (cnt_q[i] == 8'(IGNITE_TICKS - 1)) begin
                     st_d[i]      = LIT;
                     enter_lit[i] = 1'b1;
                  end else begin
                     cnt_d[i] = cnt_q[i] + 8'd1;
                  end
               end
            end
            LIT: begin
               if (tick)
                  frame_d[i] = (frame_q[i] == 3'(NUM_FRAMES - 1)) ? 3'd0 : frame_q[i] + 3'd1;
            end
            default: begin
               st_d[i]    = UNLIT;
               cnt_d[i]   = 8'd0;
               frame_d[i] = 3'd0;
            end
         endcase
      end
   end

   // Descending scan so the lowest newly lit index is the one that sticks.
   always_comb begin
      respawn_d   = respawn_q;
      active_d    = active_q;
      lit_pulse_d = 1'b0;
      for (int i = NUM_FIRES - 1; i >= 0; i--) begin
         if (enter_lit[i]) begin
            respawn_d   = {x_q[i], y_q[i], 12'b0};
            active_d    = 4'(i);
            lit_pulse_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sim_clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_FIRES; i++) begin
            x_q[i]     <= initCampfireState[32*i+22 +: 10];
            y_q[i]     <= initCampfireState[32*i+12 +: 10];
            st_q[i]    <= UNLIT;
            cnt_q[i]   <= 8'd0;
            frame_q[i] <= 3'd0;
         end
         respawn_q   <= {initCampfireState[31:12], 12'b0};
         active_q    <= 4'd0;
         lit_pulse_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_FIRES; i++) begin
            st_q[i]    <= st_d[i];
            cnt_q[i]   <= cnt_d[i];
            frame_q[i] <= frame_d[i];
         end
         respawn_q   <= respawn_d;
         active_q    <= active_d;
         lit_pulse_q <= lit_pulse_d;
      end
   end

   always_comb begin
      unused_bits = ^playerState[11:0];
      for (int i = 0; i < NUM_FIRES; i++) begin
         campfireState[32*i +: 32] = {x_q[i], y_q[i], st_q[i], frame_q[i], 7'b0};
         unused_bits = unused_bits ^ (^initCampfireState[32*i +: 12]);
      end
   end

   assign respawnState = respawn_q;
   assign activeIdx    = active_q;
   assign litPulse     = lit_pulse_q;

endmodule

// File: tb/tb_campfire_bank.sv
// Directed bench for campfire_bank: ignition, abort, simultaneous lighting, animation,
// reset mid-activity and proximity edges, with hand-computed expected words.
module tb_campfire_bank;

   logic         sim_clk = 1'b0;
   logic         reset;
   logic         tick;
   logic [127:0] initCampfireState;
   logic [31:0]  playerState;
   logic [127:0] campfireState;
   logic [31:0]  respawnState;
   logic [3:0]   activeIdx;
   logic         litPulse;

   int n_assert = 0;
   int n_fail   = 0;

   campfire_bank dut (
      .sim_clk           (sim_clk),
      .reset             (reset),
      .tick              (tick),
      .initCampfireState (initCampfireState),
      .playerState       (playerState),
      .campfireState     (campfireState),
      .respawnState      (respawnState),
      .activeIdx         (activeIdx),
      .litPulse          (litPulse)
   );

   always #5 sim_clk = ~sim_clk;

   function automatic logic [31:0] mk(input int x, input int y, input int st, input int fr);
      mk = {10'(x), 10'(y), 2'(st), 3'(fr), 7'b0};
   endfunction

   function automatic logic [31:0] pos(input int x, input int y);
      pos = {10'(x), 10'(y), 12'b0};
   endfunction

   // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
   task automatic step(input logic t);
      tick = t;
      @(posedge sim_clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ch(input int i);
      ch = campfireState[32*i +: 32];
   endfunction

   initial begin
      reset = 1'b1;
      tick  = 1'b0;
      playerState = pos(0, 0);
      initCampfireState = {pos(600, 300), pos(600, 300), pos(400, 100), pos(250, 180)};
      @(posedge sim_clk);
      #1;
      step(1'b0);
      chk("rst_ch0", ch(0), mk(250, 180, 0, 0));
      chk("rst_ch1", ch(1), mk(400, 100, 0, 0));
      chk("rst_resp", respawnState, pos(250, 180));
      chk("rst_idx", 32'(activeIdx), 32'd0);
      chk("rst_pulse", 32'(litPulse), 32'd0);
      reset = 1'b0;

      // 1: far player, ticks change nothing
      for (int k = 0; k < 10; k++) begin
         step(1'b1);
         chk("far_pulse", 32'(litPulse), 32'd0);
      end
      chk("far_ch0", ch(0), mk(250, 180, 0, 0));
      chk("far_ch2", ch(2), mk(600, 300, 0, 0));

      // 2: ignite ch0
      playerState = pos(255, 185);
      step(1'b0);
      chk("ign0_st", ch(0), mk(250, 180, 1, 0));
      for (int k = 0; k < 7; k++) step(1'b1);
      chk("ign0_7", ch(0), mk(250, 180, 1, 0));
      chk("ign0_7_pulse", 32'(litPulse), 32'd0);
      step(1'b1);
      chk("lit0", ch(0), mk(250, 180, 2, 0));
      chk("lit0_pulse", 32'(litPulse), 32'd1);
      chk("lit0_idx", 32'(activeIdx), 32'd0);
      chk("lit0_resp", respawnState, pos(250, 180));

      // 5: animation 1,2,3,0,1,2,3,0,1
      for (int k = 0; k < 9; k++) begin
         step(1'b1);
         chk("frame", ch(0), mk(250, 180, 2, (k + 1) % 4));
         chk("frame_pulse", 32'(litPulse), 32'd0);
      end

      // 3: partial ignition of ch1, abort, fresh ignition
      playerState = pos(400, 100);
      step(1'b0);
      chk("ign1_st", ch(1), mk(400, 100, 1, 0));
      for (int k = 0; k < 5; k++) step(1'b1);
      chk("ign1_5", ch(1), mk(400, 100, 1, 0));
      playerState = pos(0, 0);
      step(1'b0);
      chk("abort1", ch(1), mk(400, 100, 0, 0));
      playerState = pos(400, 100);
      step(1'b0);
      for (int k = 0; k < 7; k++) step(1'b1);
      chk("reign1_7", ch(1), mk(400, 100, 1, 0));
      step(1'b1);
      chk("lit1", ch(1), mk(400, 100, 2, 0));
      chk("lit1_pulse", 32'(litPulse), 32'd1);
      chk("lit1_idx", 32'(activeIdx), 32'd1);
      chk("lit1_resp", respawnState, pos(400, 100));

      // 4: ch2 and ch3 light together
      playerState = pos(600, 300);
      step(1'b0);
      chk("ign2", ch(2), mk(600, 300, 1, 0));
      chk("ign3", ch(3), mk(600, 300, 1, 0));
      for (int k = 0; k < 8; k++) step(1'b1);
      chk("lit2", ch(2), mk(600, 300, 2, 0));
      chk("lit3", ch(3), mk(600, 300, 2, 0));
      chk("lit23_idx", 32'(activeIdx), 32'd2);
      chk("lit23_resp", respawnState, pos(600, 300));
      chk("lit23_pulse", 32'(litPulse), 32'd1);
      step(1'b0);
      chk("lit23_pulse_end", 32'(litPulse), 32'd0);
      chk("lit23_idx_hold", 32'(activeIdx), 32'd2);

      // 6: reset with new init words while fires are lit, then mid-ignition
      initCampfireState = {pos(900, 900), pos(1020, 500), pos(700, 400), pos(100, 50)};
      playerState = pos(0, 0);
      reset = 1'b1;
      step(1'b1);
      reset = 1'b0;
      chk("rst2_ch0", ch(0), mk(100, 50, 0, 0));
      chk("rst2_ch1", ch(1), mk(700, 400, 0, 0));
      chk("rst2_ch2", ch(2), mk(1020, 500, 0, 0));
      chk("rst2_ch3", ch(3), mk(900, 900, 0, 0));
      chk("rst2_resp", respawnState, pos(100, 50));
      chk("rst2_idx", 32'(activeIdx), 32'd0);
      step(1'b0);
      chk("rst2_hold", ch(1), mk(700, 400, 0, 0));
      playerState = pos(100, 50);
      step(1'b0);
      for (int k = 0; k < 3; k++) step(1'b1);
      chk("mid_ign", ch(0), mk(100, 50, 1, 0));
      reset = 1'b1;
      step(1'b1);
      reset = 1'b0;
      chk("rst3_ch0", ch(0), mk(100, 50, 0, 0));
      chk("rst3_idx", 32'(activeIdx), 32'd0);

      // 7: proximity edges around ch0=(100,50) and ch2=(1020,500)
      playerState = pos(115, 50);  step(1'b0);
      chk("edge_x15", ch(0), mk(100, 50, 1, 0));
      playerState = pos(116, 50);  step(1'b0);
      chk("edge_x16", ch(0), mk(100, 50, 0, 0));
      playerState = pos(85, 50);   step(1'b0);
      chk("edge_xm15", ch(0), mk(100, 50, 1, 0));
      playerState = pos(84, 50);   step(1'b0);
      chk("edge_xm16", ch(0), mk(100, 50, 0, 0));
      playerState = pos(100, 65);  step(1'b0);
      chk("edge_y15", ch(0), mk(100, 50, 1, 0));
      playerState = pos(100, 66);  step(1'b0);
      chk("edge_y16", ch(0), mk(100, 50, 0, 0));
      playerState = pos(5, 500);   step(1'b0);
      chk("edge_wrap", ch(2), mk(1020, 500, 0, 0));
      playerState = pos(1005, 500); step(1'b0);
      chk("edge_hi", ch(2), mk(1020, 500, 1, 0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed no finish, expected finish");
      $fatal(1, "timeout");
   end

endmodule
